// File: rtl/gascon_pkg.sv
// Shared types and defaults for the Gascon multi-round sequencer.
package gascon_pkg;

   localparam int GASCON_CWIDTH     = 320;
   localparam int GASCON_RWIDTH     = 16;
   localparam int GASCON_NUM_ROUNDS = 12;
   localparam int GASCON_TIMEOUT    = 255;

   // Sequencer states: wait for input, reset core, run core, present result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CRST = 2'd1,
      CRUN = 2'd2,
      OUT  = 2'd3
   } seq_state_t;

   // Watchdog width large enough to hold the TIMEOUT terminal count.
   function automatic int wdog_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/gascon_perm_seq_if.sv
// Input/output stream handshakes of the Gascon sequencer.
interface gascon_perm_seq_if #(
   parameter int CWIDTH = gascon_pkg::GASCON_CWIDTH,
   parameter int RWIDTH = gascon_pkg::GASCON_RWIDTH
) ();

   logic              in_valid;
   logic              in_ready;
   logic [CWIDTH-1:0] in_state;
   logic [RWIDTH-1:0] start_round;
   logic              out_valid;
   logic              out_ready;
   logic [CWIDTH-1:0] out_state;
   logic              error;

   // Producer of states and consumer of results.
   modport master (
      output in_valid, in_state, start_round, out_ready,
      input  in_ready, out_valid, out_state, error
   );

   // The sequencer side.
   modport slave (
      input  in_valid, in_state, start_round, out_ready,
      output in_ready, out_valid, out_state, error
   );

endinterface

// File: rtl/gascon_watchdog.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
module gascon_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int WIDTH   = gascon_pkg::wdog_width(TIMEOUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count up while enabled; clear has priority over load, load over count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign tc_o = (cnt_q == WIDTH'(TIMEOUT));

endmodule

// File: rtl/gascon_perm_seq.sv
// Multi-round sequencer driving a single-round Gascon core.
// Each round: one CRST cycle (core held in reset) then CRUN until core_done
// or the watchdog expires. The round result is fed back through st_q.
module gascon_perm_seq
   import gascon_pkg::*;
#(
   parameter int CWIDTH     = GASCON_CWIDTH,
   parameter int RWIDTH     = GASCON_RWIDTH,
   parameter int NUM_ROUNDS = GASCON_NUM_ROUNDS,
   parameter int TIMEOUT    = GASCON_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   gascon_perm_seq_if.slave  bus,
   output logic              busy,
   output logic [CWIDTH-1:0] core_c,
   output logic [RWIDTH-1:0] core_round,
   output logic              core_en,
   output logic              core_reset,
   input  logic [CWIDTH-1:0] core_cout,
   input  logic              core_done
);

   localparam int                WDOG_W   = wdog_width(TIMEOUT);
   localparam logic [RWIDTH-1:0] LAST_RND = RWIDTH'(NUM_ROUNDS);

   seq_state_t        state_q;
   logic [CWIDTH-1:0] st_q;
   logic [RWIDTH-1:0] rnd_q;
   logic              err_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              core_en_q;
   logic              core_reset_q;

   logic [RWIDTH-1:0] rnd_d;
   logic              wdog_clr;
   logic              wdog_en;
   logic              wdog_tc;

   assign rnd_d    = rnd_q + RWIDTH'(1);
   assign wdog_clr = (state_q == CRST);
   assign wdog_en  = (state_q == CRUN);

   gascon_watchdog #(
      .TIMEOUT (TIMEOUT),
      .WIDTH   (WDOG_W)
   ) u_wdog (
      .clk        (clk),
      .rst_n      (reset_n),
      .clr_i      (wdog_clr),
      .en_i       (wdog_en),
      .load_i     (1'b0),
      .load_val_i ('0),
      .tc_o       (wdog_tc)
   );

   // Sequencer FSM with registered handshake and core-control outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         // NOTE: the wide state register is reset too, because out_state and
         // core_c must read zero while reset_n is low.
         st_q         <= '0;
         rnd_q        <= '0;
         err_q        <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         core_en_q    <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments throughout, so every decision below
         // sees the pre-edge register values regardless of statement order.
         case (state_q)
            IDLE: begin
               if (in_ready_q && bus.in_valid) begin
                  st_q       <= bus.in_state;
                  rnd_q      <= bus.start_round;
                  err_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.start_round >= LAST_RND) begin
                     state_q     <= OUT;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= CRST;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end

            CRST: begin
               state_q      <= CRUN;
               core_en_q    <= 1'b1;
               core_reset_q <= 1'b0;
            end

            CRUN: begin
               if (core_done) begin
                  st_q         <= core_cout;
                  rnd_q        <= rnd_d;
                  core_en_q    <= 1'b0;
                  core_reset_q <= 1'b1;
                  if (rnd_d == LAST_RND) begin
                     state_q     <= OUT;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= CRST;
                  end
               end else if (wdog_tc) begin
                  err_q        <= 1'b1;
                  core_en_q    <= 1'b0;
                  core_reset_q <= 1'b1;
                  state_q      <= OUT;
                  out_valid_q  <= 1'b1;
               end
            end

            OUT: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q      <= IDLE;
               in_ready_q   <= 1'b0;
               out_valid_q  <= 1'b0;
               busy_q       <= 1'b0;
               core_en_q    <= 1'b0;
               core_reset_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = st_q;
   assign bus.error     = err_q;
   assign busy          = busy_q;
   assign core_c        = st_q;
   assign core_round    = rnd_q;
   assign core_en       = core_en_q;
   // Core reset follows reset_n combinationally so the core is held from the
   // moment reset asserts, not from the next clock edge.
   assign core_reset    = core_reset_q | ~reset_n;

endmodule

// File: doc/gascon_perm_seq.md
# gascon_perm_seq

Multi-round sequencer for the Gascon permutation. It accepts a full CWIDTH-bit state over a valid/ready handshake and drives the single-round Gascon core once per round, supplying the round index each time. It feeds each round's output back as the next round's input and presents the final permuted state over a valid/ready output handshake. It sits directly upstream of the round core and owns that core's reset, enable and round inputs.

## Interface
- CWIDTH, 320, state width in bits (multiple of 64)
- RWIDTH, 16, width of the core round-index port
- NUM_ROUNDS, 12, index of the last round + 1; rounds run start_round..NUM_ROUNDS-1
- TIMEOUT, 255, maximum cycles spent in CRUN per round before abort
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_state/start_round valid
- in_ready  out  1  sequencer can accept a state
- in_state  in  CWIDTH  state to permute
- start_round  in  RWIDTH  first round index
- out_valid  out  1  out_state valid
- out_ready  in  1  consumer accepts out_state
- out_state  out  CWIDTH  permuted state
- error  out  1  round timed out; qualified by out_valid
- busy  out  1  high in any state other than IDLE
- core_c  out  CWIDTH  state presented to the round core
- core_round  out  RWIDTH  round index presented to the core
- core_en  out  1  core enable
- core_reset  out  1  core synchronous reset, active-high
- core_cout  in  CWIDTH  core result, valid while core_done = 1
- core_done  in  1  core finished the current round

## Operation
- Registers:
  - st_reg (CWIDTH)
  - rnd (RWIDTH)
  - wdog (8 bits, sized from TIMEOUT)
  - err
- States: IDLE, CRST, CRUN, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid, st_reg <= in_state, rnd <= start_round, err <= 0.
  - If start_round >= NUM_ROUNDS (unsigned compare), go to OUT. This is the zero-round pass-through.
  - Otherwise go to CRST.
- CRST:
  - core_reset = 1, core_en = 0, wdog <= 0.
  - Next state is CRUN.
- CRUN:
  - core_reset = 0, core_en = 1 for the whole state.
  - wdog increments each cycle.
  - On core_done = 1: st_reg <= core_cout and rnd <= rnd + 1. If rnd + 1 == NUM_ROUNDS go to OUT, else go to CRST.
  - If wdog == TIMEOUT and core_done = 0: err <= 1, st_reg unchanged, go to OUT.
- OUT:
  - out_valid = 1, out_state = st_reg, error = err.
  - On out_ready go to IDLE.
  - out_state and error hold stable while out_ready = 0.
- core_c = st_reg and core_round = rnd at all times. Both are stable for the entire CRST/CRUN span of each round.
- core_reset = 1 in IDLE, CRST, OUT, and whenever reset_n = 0. It is high combinationally during reset.
- in_valid outside IDLE is ignored; there is no queuing.
- Arithmetic: rnd + 1 is computed in RWIDTH bits. Wrap is impossible because rnd < NUM_ROUNDS in CRUN.

## Timing
- Reset values (reset_n low):
  - in_ready = 0, out_valid = 0, busy = 0, error = 0, core_en = 0.
  - out_state, core_c and core_round = 0.
  - core_reset = 1.
- The FSM enters IDLE, and in_ready rises on the first clk edge after reset_n deasserts.
- Reset mid-operation aborts immediately. The in-flight state is discarded and no out_valid is produced.
- Latency:
  - The accepting edge is cycle 0.
  - With D = CRUN cycles per round (inclusive of the done cycle), out_valid rises at cycle 1 + R·(1 + D), where R = NUM_ROUNDS − start_round.
  - For R = 0, out_valid rises at cycle 1.
- Back-to-back: an output handshake at cycle n gives in_ready = 1 at cycle n+1. There is no same-cycle in→out overlap.
- Timeout: CRUN lasts at most TIMEOUT+1 cycles per round.

## Structure
- Package gascon_pkg holds:
  - the seq_state_t enum (IDLE, CRST, CRUN, OUT)
  - default NUM_ROUNDS = 12
  - GASCON_CWIDTH = 320
- The round core is instantiated by the parent, not inside this block.
- One sub-module is natural: gascon_watchdog. It is a loadable up-counter with clear/enable inputs and a terminal-count flag, parameterised by TIMEOUT.
- The rest is a single flat FSM with datapath.

## Test plan
- Full permutation:
  - Stimulus: in_state = 0, start_round = 0, bench core stub with D = 4.
  - Required: core_round steps 0..11, out_valid at cycle 61, out_state = golden 12-round result, error = 0.
- Partial permutation:
  - Stimulus: start_round = 6, D = 4.
  - Required: core_round sequence 6..11 exactly, out_valid at cycle 31, out_state matches golden model.
- Zero rounds:
  - Stimulus: start_round = 12, in_state = 0x0123…CDEF pattern.
  - Required: core_en never high, out_valid at cycle 1, out_state == in_state.
- Backpressure:
  - Stimulus: out_ready held low 10 cycles after out_valid.
  - Required: out_state constant, in_ready = 0, busy = 1 throughout. After the handshake, in_ready = 1 the next cycle.
- Timeout:
  - Stimulus: stub holds core_done = 0 in round 3.
  - Required: out_valid after 256 CRUN cycles with error = 1, and out_state = result after round 2.
- Reset mid-run:
  - Stimulus: reset_n low during round 5.
  - Required: core_reset = 1 and out_valid = 0 the same cycle, no output produced. in_ready = 1 one edge after release.
